rggen_external_window_array: RTL and testbench

Multi-window external register bridge: decodes up to WINDOWS independent address windows and forwards each hit as a request on one shared external bus, with a select vector identifying the target window. Adds a request/response state machine with a registered response and an optional watchdog timeout. Sits in the generated register block alongside ordinary registers, on the internal register bus; the external port connects to user logic or a downstream bus bridge.

---
 rtl/rggen_external_window_array.sv | 149 ++++++++++++++
 tb/tb_rggen_external_window_array.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rggen_external_window_array.sv
// Multi-window external register bridge: decodes WINDOWS address windows onto one shared external bus.
// Optional watchdog is enabled by defining RGGEN_EXTERNAL_WINDOW_TIMEOUT_EN.
module rggen_external_window_array #(
    parameter int                               ADDRESS_WIDTH   = 8,
    parameter int                               BUS_WIDTH       = 32,
    parameter int                               STROBE_WIDTH    = BUS_WIDTH / 8,
    parameter int                               WINDOWS         = 2,
    parameter logic [WINDOWS*ADDRESS_WIDTH-1:0] START_ADDRESSES = '0,
    parameter logic [WINDOWS*ADDRESS_WIDTH-1:0] BYTE_SIZES      = '0,
    parameter int                               TIMEOUT_CYCLES  = 64,
    parameter logic [1:0]                       TIMEOUT_STATUS  = 2'b10
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_register_valid,
    input  logic [1:0]               i_register_access,
    input  logic [ADDRESS_WIDTH-1:0] i_register_address,
    input  logic [BUS_WIDTH-1:0]     i_register_write_data,
    input  logic [BUS_WIDTH-1:0]     i_register_strobe,
    output logic                     o_register_active,
    output logic                     o_register_ready,
    output logic [1:0]               o_register_status,
    output logic [BUS_WIDTH-1:0]     o_register_read_data,
    output logic [BUS_WIDTH-1:0]     o_register_value,
    output logic                     o_external_valid,
    output logic [WINDOWS-1:0]       o_external_select,
    output logic [1:0]               o_external_access,
    output logic [ADDRESS_WIDTH-1:0] o_external_address,
    output logic [BUS_WIDTH-1:0]     o_external_data,
    output logic [STROBE_WIDTH-1:0]  o_external_strobe,
    input  logic                     i_external_ready,
    input  logic [1:0]               i_external_status,
    input  logic [BUS_WIDTH-1:0]     i_external_data
);
    // Handshake: the register side holds i_register_valid until o_register_ready pulses;
    // the external side sees o_external_valid with stable fields until i_external_ready is sampled high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e state;
    state_e state_next;

    logic [ADDRESS_WIDTH-1:0] aligned_address;
    logic [WINDOWS-1:0]       window_hit;
    logic [ADDRESS_WIDTH-1:0] window_offset [WINDOWS];
    logic [WINDOWS-1:0]       hit_select;
    logic [ADDRESS_WIDTH-1:0] hit_offset;
    logic [STROBE_WIDTH-1:0]  byte_strobe;
    logic                     accept;
    logic                     timeout;

    // Sub-word address bits never affect which window is hit.
    assign aligned_address = i_register_address & ~ADDRESS_WIDTH'(BUS_WIDTH / 8 - 1);

    for (genvar w = 0; w < WINDOWS; w++) begin : g_window
        localparam logic [ADDRESS_WIDTH:0] START = {1'b0, START_ADDRESSES[w*ADDRESS_WIDTH+:ADDRESS_WIDTH]};
        localparam logic [ADDRESS_WIDTH:0] LIMIT = START + {1'b0, BYTE_SIZES[w*ADDRESS_WIDTH+:ADDRESS_WIDTH]};
        assign window_hit[w]    = ({1'b0, aligned_address} >= START) && ({1'b0, aligned_address} < LIMIT);
        assign window_offset[w] = i_register_address - START[ADDRESS_WIDTH-1:0];
    end

    // Descending scan so the lowest-indexed overlapping window is the one kept.
    always_comb begin
        hit_select = '0;
        hit_offset = '0;
        for (int w = WINDOWS - 1; w >= 0; w--) begin
            if (window_hit[w]) begin
                hit_select    = '0;
                hit_select[w] = 1'b1;
                hit_offset    = window_offset[w];
            end
        end
    end

    for (genvar b = 0; b < STROBE_WIDTH; b++) begin : g_byte_strobe
        assign byte_strobe[b] = |i_register_strobe[8*b+:8];
    end

    assign o_register_active = |window_hit;
    assign accept            = i_register_valid && (|window_hit);

`ifdef RGGEN_EXTERNAL_WINDOW_TIMEOUT_EN
    localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    logic [COUNT_WIDTH-1:0] timeout_count;

    // Held at zero while idle so every BUSY entry starts counting from zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            timeout_count <= '0;
        end else if (state == IDLE) begin
            timeout_count <= '0;
        end else if (state == BUSY) begin
            timeout_count <= timeout_count + 1'b1;
        end
    end

    assign timeout = (state == BUSY) && (timeout_count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (i_external_ready || timeout) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state                <= IDLE;
            o_external_select    <= '0;
            o_external_access    <= '0;
            o_external_address   <= '0;
            o_external_data      <= '0;
            o_external_strobe    <= '0;
            o_register_status    <= '0;
            o_register_read_data <= '0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && accept) begin
                o_external_select  <= hit_select;
                o_external_access  <= i_register_access;
                o_external_address <= hit_offset;
                o_external_data    <= i_register_write_data;
                o_external_strobe  <= byte_strobe;
            end
            // A ready arriving on the watchdog's last cycle still delivers the real response.
            if ((state == BUSY) && i_external_ready) begin
                o_register_status    <= i_external_status;
                o_register_read_data <= i_external_data;
            end else if (timeout) begin
                o_register_status    <= TIMEOUT_STATUS;
                o_register_read_data <= '0;
            end
        end
    end

    assign o_external_valid = (state == BUSY);
    assign o_register_ready = (state == RESP);
    assign o_register_value = o_register_read_data;

endmodule

// File: tb/tb_rggen_external_window_array.sv
// Directed bench for rggen_external_window_array: vector table plus reset, back-to-back and watchdog sequences.
// Watchdog sequences follow RGGEN_EXTERNAL_WINDOW_TIMEOUT_EN as the RTL does.
module tb_rggen_external_window_array;
    logic        clk;
    logic        rst_n;
    logic        reg_valid;
    logic [1:0]  reg_access;
    logic [7:0]  reg_address;
    logic [31:0] reg_wdata;
    logic [31:0] reg_strobe;
    logic        reg_active;
    logic        reg_ready;
    logic [1:0]  reg_status;
    logic [31:0] reg_rdata;
    logic [31:0] reg_value;
    logic        ext_valid;
    logic [1:0]  ext_select;
    logic [1:0]  ext_access;
    logic [7:0]  ext_address;
    logic [31:0] ext_wdata;
    logic [3:0]  ext_strobe;
    logic        ext_ready;
    logic [1:0]  ext_status;
    logic [31:0] ext_rdata;

    int check_count = 0;
    int pass_count  = 0;

    rggen_external_window_array #(
        .ADDRESS_WIDTH  (8),
        .BUS_WIDTH      (32),
        .WINDOWS        (2),
        .START_ADDRESSES({8'h40, 8'h00}),
        .BYTE_SIZES     ({8'h20, 8'h20}),
        .TIMEOUT_CYCLES (4),
        .TIMEOUT_STATUS (2'b10)
    ) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_register_valid     (reg_valid),
        .i_register_access    (reg_access),
        .i_register_address   (reg_address),
        .i_register_write_data(reg_wdata),
        .i_register_strobe    (reg_strobe),
        .o_register_active    (reg_active),
        .o_register_ready     (reg_ready),
        .o_register_status    (reg_status),
        .o_register_read_data (reg_rdata),
        .o_register_value     (reg_value),
        .o_external_valid     (ext_valid),
        .o_external_select    (ext_select),
        .o_external_access    (ext_access),
        .o_external_address   (ext_address),
        .o_external_data      (ext_wdata),
        .o_external_strobe    (ext_strobe),
        .i_external_ready     (ext_ready),
        .i_external_status    (ext_status),
        .i_external_data      (ext_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  access;
        logic [7:0]  address;
        logic [31:0] wdata;
        logic [31:0] strobe;
        int          latency;
        logic [1:0]  rsp_status;
        logic [31:0] rsp_data;
        logic        exp_active;
        logic [1:0]  exp_select;
        logic [7:0]  exp_offset;
        logic [3:0]  exp_bstrobe;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One full register transaction, checking every phase of both handshakes.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        reg_valid   = 1'b1;
        reg_access  = v.access;
        reg_address = v.address;
        reg_wdata   = v.wdata;
        reg_strobe  = v.strobe;
        #1;
        check("active", reg_active, v.exp_active);
        if (!v.exp_active) begin
            repeat (3) begin
                @(negedge clk);
                check("miss_ext_valid", ext_valid, 0);
                check("miss_reg_ready", reg_ready, 0);
            end
            reg_valid = 1'b0;
            return;
        end
        @(negedge clk);
        check("ext_valid", ext_valid, 1);
        check("ext_select", ext_select, v.exp_select);
        check("ext_address", ext_address, v.exp_offset);
        check("ext_access", ext_access, v.access);
        check("ext_data", ext_wdata, v.wdata);
        check("ext_strobe", ext_strobe, v.exp_bstrobe);
        for (int i = 0; i < v.latency; i++) begin
            @(negedge clk);
            check("wait_ext_valid", ext_valid, 1);
            check("wait_reg_ready", reg_ready, 0);
        end
        ext_ready  = 1'b1;
        ext_status = v.rsp_status;
        ext_rdata  = v.rsp_data;
        @(negedge clk);
        check("resp_reg_ready", reg_ready, 1);
        check("resp_ext_valid", ext_valid, 0);
        check("resp_status", reg_status, v.rsp_status);
        check("resp_rdata", reg_rdata, v.rsp_data);
        check("resp_value", reg_value, v.rsp_data);
        ext_ready  = 1'b0;
        ext_status = 2'b11;
        ext_rdata  = 32'hBAD0BAD0;
        reg_valid  = 1'b0;
        @(negedge clk);
        check("idle_reg_ready", reg_ready, 0);
        check("hold_status", reg_status, v.rsp_status);
        check("hold_rdata", reg_rdata, v.rsp_data);
    endtask

    initial begin
        rst_n       = 1'b0;
        reg_valid   = 1'b0;
        reg_access  = 2'b00;
        reg_address = 8'h00;
        reg_wdata   = '0;
        reg_strobe  = '0;
        ext_ready   = 1'b0;
        ext_status  = 2'b00;
        ext_rdata   = '0;

        //        access  addr   wdata         strobe        lat rsp    rsp_data      act sel    off    bstrb
        vecs[0] = '{2'b00, 8'h44, 32'h0,        32'h0,        3, 2'b00, 32'hDEADBEEF, 1, 2'b10, 8'h04, 4'b0000};
        vecs[1] = '{2'b01, 8'h10, 32'h12345678, 32'h0000FFFF, 0, 2'b00, 32'h0,        1, 2'b01, 8'h10, 4'b0011};
        vecs[2] = '{2'b00, 8'h30, 32'h0,        32'h0,        0, 2'b00, 32'h0,        0, 2'b00, 8'h00, 4'b0000};
        vecs[3] = '{2'b01, 8'h1C, 32'hA5A5A5A5, 32'hFF000000, 1, 2'b01, 32'h0,        1, 2'b01, 8'h1C, 4'b1000};
        vecs[4] = '{2'b00, 8'h5F, 32'h0,        32'h0,        0, 2'b11, 32'hCAFEF00D, 1, 2'b10, 8'h1F, 4'b0000};
        vecs[5] = '{2'b00, 8'h20, 32'h0,        32'h0,        0, 2'b00, 32'h0,        0, 2'b00, 8'h00, 4'b0000};
        vecs[6] = '{2'b00, 8'h60, 32'h0,        32'h0,        0, 2'b00, 32'h0,        0, 2'b00, 8'h00, 4'b0000};
        vecs[7] = '{2'b00, 8'h00, 32'h0,        32'h00FF00F0, 2, 2'b00, 32'h00000001, 1, 2'b01, 8'h00, 4'b0101};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_ext_valid", ext_valid, 0);
        check("rst_reg_ready", reg_ready, 0);
        check("rst_status", reg_status, 0);
        check("rst_rdata", reg_rdata, 0);
        check("rst_value", reg_value, 0);
        check("rst_select", ext_select, 0);
        check("rst_address", ext_address, 0);
        check("rst_access", ext_access, 0);
        check("rst_data", ext_wdata, 0);
        check("rst_strobe", ext_strobe, 0);
        check("rst_active_addr0", reg_active, 1);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Back-to-back with ready held high: accept, valid, response, accept ... every 3 cycles.
        @(negedge clk);
        reg_valid   = 1'b1;
        reg_access  = 2'b00;
        reg_address = 8'h48;
        ext_ready   = 1'b1;
        ext_status  = 2'b00;
        ext_rdata   = 32'h11111111;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("b2b_ext_valid", ext_valid, (i % 3 == 0) ? 1 : 0);
            check("b2b_reg_ready", reg_ready, (i % 3 == 1) ? 1 : 0);
            if (i % 3 == 1) check("b2b_rdata", reg_rdata, 32'h11111111);
        end
        reg_valid = 1'b0;
        ext_ready = 1'b0;
        @(negedge clk);
        check("b2b_quiet", ext_valid, 0);

        // Reset while BUSY abandons the request.
        @(negedge clk);
        reg_valid   = 1'b1;
        reg_access  = 2'b01;
        reg_address = 8'h08;
        @(negedge clk);
        check("mid_rst_busy", ext_valid, 1);
        rst_n     = 1'b0;
        reg_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_ext_valid", ext_valid, 0);
        check("mid_rst_select", ext_select, 0);
        check("mid_rst_reg_ready", reg_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_reg_ready", reg_ready, 0);
        check("post_rst_ext_valid", ext_valid, 0);
        run_vec(vecs[0]);

`ifdef RGGEN_EXTERNAL_WINDOW_TIMEOUT_EN
        // Ready never arrives: response after 4 BUSY cycles with the timeout status.
        @(negedge clk);
        reg_valid   = 1'b1;
        reg_access  = 2'b00;
        reg_address = 8'h04;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("to_busy", ext_valid, 1);
            check("to_no_ready", reg_ready, 0);
        end
        @(negedge clk);
        check("to_reg_ready", reg_ready, 1);
        check("to_status", reg_status, 2'b10);
        check("to_rdata", reg_rdata, 0);
        reg_valid = 1'b0;
        @(negedge clk);
        check("to_idle", reg_ready, 0);

        // Ready on the watchdog's final cycle wins.
        @(negedge clk);
        reg_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("tor_busy", ext_valid, 1);
            if (k == 4) begin
                ext_ready  = 1'b1;
                ext_status = 2'b01;
                ext_rdata  = 32'h00000077;
            end
        end
        @(negedge clk);
        check("tor_reg_ready", reg_ready, 1);
        check("tor_status", reg_status, 2'b01);
        check("tor_rdata", reg_rdata, 32'h00000077);
        ext_ready = 1'b0;
        reg_valid = 1'b0;
        @(negedge clk);
`else
        // Without the watchdog BUSY waits for ready indefinitely.
        @(negedge clk);
        reg_valid   = 1'b1;
        reg_access  = 2'b00;
        reg_address = 8'h04;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("nto_busy", ext_valid, 1);
            check("nto_no_ready", reg_ready, 0);
        end
        ext_ready  = 1'b1;
        ext_status = 2'b01;
        ext_rdata  = 32'h00000077;
        @(negedge clk);
        check("nto_reg_ready", reg_ready, 1);
        check("nto_status", reg_status, 2'b01);
        check("nto_rdata", reg_rdata, 32'h00000077);
        ext_ready = 1'b0;
        reg_valid = 1'b0;
        @(negedge clk);
`endif
        check("final_idle", ext_valid, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
